proc_ctrl: RTL and testbench

//  Control FSM for the 9-bit lab processor. Holds the instruction register and sequences one

---
 rtl/proc_pkg.sv | 34 +++
 rtl/proc_ctrl_dec3to8.sv | 13 +
 rtl/proc_ctrl.sv | 108 ++++++++++
 tb/tb_proc_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types for the 9-bit lab processor: opcodes, controller states, ALU ops.
// The controller, ALU and datapath all import this package.
package proc_pkg;

  localparam int W    = 9;
  localparam int NREG = 8;

  typedef enum logic [2:0] {
    OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOP6, OP_NOP7
  } opcode_t;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;

  function automatic logic is_alu(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // add/sub land in G; and/or land in GF
  function automatic logic is_arith(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic alu_op_t alu_op_of(opcode_t op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_ctrl_dec3to8.sv
// 3-bit register index to 8-bit one-hot select, forced to zero when disabled.
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] idx_i,
  output logic [7:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl.sv
// Control FSM for the 9-bit lab processor: holds IR and sequences one instruction
// at a time over the shared bus with Moore-decoded selects and load enables.
module proc_ctrl
  import proc_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic [W-1:0]    din_i,
  output logic            ir_in_o,
  output logic [NREG-1:0] rin_o,
  output logic [NREG-1:0] rout_o,
  output logic            dinout_o,
  output logic            gout_o,
  output logic            gfout_o,
  output logic            ain_o,
  output logic            gin_o,
  output logic            gfin_o,
  output logic [1:0]      alu_op_o,
  output logic            done_o,
  output logic [W-1:0]    ir_o
);

  state_t        state_q, state_d;
  logic [W-1:0]  ir_q, ir_d;
  opcode_t       op;
  logic [NREG-1:0] x_oh, y_oh;
  logic          busy;

  assign op    = opcode_t'(ir_q[8:6]);
  assign busy  = (state_q != T0);
  assign ir_o  = ir_q;

  // Index decoders are held off in T0 so no select can leak while idle.
  dec3to8 u_dec_x (.en_i(busy), .idx_i(ir_q[5:3]), .onehot_o(x_oh));
  dec3to8 u_dec_y (.en_i(busy), .idx_i(ir_q[2:0]), .onehot_o(y_oh));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = T0;
    ir_d     = ir_q;
    ir_in_o  = 1'b0;
    rin_o    = '0;
    rout_o   = '0;
    dinout_o = 1'b0;
    gout_o   = 1'b0;
    gfout_o  = 1'b0;
    ain_o    = 1'b0;
    gin_o    = 1'b0;
    gfin_o   = 1'b0;
    alu_op_o = ALU_ADD;
    done_o   = 1'b0;
    case (state_q)
      T0: begin
        ir_in_o = run_i;
        if (run_i) begin
          ir_d    = din_i;
          state_d = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            rout_o = y_oh;
            rin_o  = x_oh;
            done_o = 1'b1;
          end
          OP_MVI: begin
            dinout_o = 1'b1;
            rin_o    = x_oh;
            done_o   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            rout_o  = x_oh;
            ain_o   = 1'b1;
            state_d = T2;
          end
          default: done_o = 1'b1;
        endcase
      end
      T2: begin
        // Only ALU opcodes reach T2; A already holds Rx, bus carries Ry.
        rout_o   = y_oh;
        alu_op_o = alu_op_of(op);
        gin_o    = is_arith(op);
        gfin_o   = is_alu(op) && !is_arith(op);
        state_d  = T3;
      end
      T3: begin
        gout_o  = is_arith(op);
        gfout_o = is_alu(op) && !is_arith(op);
        rin_o   = x_oh;
        done_o  = 1'b1;
      end
      default: state_d = T0;
    endcase
  end

endmodule

// File: tb/tb_proc_ctrl.sv
// Randomized bench for proc_ctrl: a behavioural register-file model plus a small
// datapath driven by the controller outputs, with per-cycle control checks.
module tb_proc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [8:0] din = '0;
  logic       ir_in, dinout, gout, gfout, ain, gin, gfin, done;
  logic [7:0] rin, rout;
  logic [1:0] alu_op;
  logic [8:0] ir;

  int total = 0;
  int bad   = 0;

  proc_ctrl dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .din_i(din),
    .ir_in_o(ir_in), .rin_o(rin), .rout_o(rout), .dinout_o(dinout),
    .gout_o(gout), .gfout_o(gfout), .ain_o(ain), .gin_o(gin), .gfin_o(gfin),
    .alu_op_o(alu_op), .done_o(done), .ir_o(ir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bench datapath: R0-R7, A, G, GF and the bus mux, steered only by DUT outputs.
  logic [8:0] R [8] = '{default: 9'd0};
  logic [8:0] A = '0, G = '0, GF = '0, bus;

  always_comb begin
    bus = '0;
    for (int i = 0; i < 8; i++) if (rout[i]) bus |= R[i];
    if (dinout) bus |= din;
    if (gout)   bus |= G;
    if (gfout)  bus |= GF;
    if ($countones({rout, dinout, gout, gfout}) != 1) bus = '0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (rin[i]) R[i] <= bus;
    if (ain) A <= bus;
    if (gin) G <= (alu_op == 2'b00) ? A + bus : A - bus;
    if (gfin) GF <= (alu_op == 2'b10) ? (A & bus) : (A | bus);
  end

  always @(negedge clk) begin
    chk("bus_onehot", 32'($countones({rout, dinout, gout, gfout}) <= 1), 32'd1);
    chk("rin_onehot", 32'($countones(rin) <= 1), 32'd1);
  end

  // Reference register contents, updated once per completed instruction.
  logic [8:0] mr [8] = '{default: 9'd0};

  function automatic logic [24:0] obs();
    return {rin, rout, dinout, gout, gfout, ain, gin, gfin, alu_op, done};
  endfunction

  // Expected control word for cycle c (1..3) of an instruction, straight from the sequencing table.
  function automatic logic [24:0] exp_out(input logic [2:0] op, input logic [2:0] x,
                                          input logic [2:0] y, input int c);
    logic [7:0] e_rin = '0, e_rout = '0, xo, yo;
    logic e_dout = 0, e_gout = 0, e_gfout = 0, e_ain = 0, e_gin = 0, e_gfin = 0, e_done = 0;
    logic [1:0] e_alu = 2'b00;
    xo = 8'd1 << x;
    yo = 8'd1 << y;
    if (c == 1) begin
      if (op == 3'd0) begin e_rout = yo; e_rin = xo; e_done = 1; end
      else if (op == 3'd1) begin e_dout = 1; e_rin = xo; e_done = 1; end
      else if (op >= 3'd2 && op <= 3'd5) begin e_rout = xo; e_ain = 1; end
      else e_done = 1;
    end else if (c == 2) begin
      e_rout = yo;
      e_alu  = 2'(op - 3'd2);
      if (op < 3'd4) e_gin = 1; else e_gfin = 1;
    end else begin
      if (op < 3'd4) e_gout = 1; else e_gfout = 1;
      e_rin  = xo;
      e_done = 1;
    end
    return {e_rin, e_rout, e_dout, e_gout, e_gfout, e_ain, e_gin, e_gfin, e_alu, e_done};
  endfunction

  task automatic idle(input logic [8:0] ir_exp);
    run = 0;
    din = 9'($urandom);
    @(negedge clk);
    chk("idle_out", 32'(obs()), 32'd0);
    chk("idle_irin", 32'(ir_in), 32'd0);
    chk("idle_ir", 32'(ir), 32'(ir_exp));
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [8:0] ins, input logic [8:0] imm);
    logic [2:0] op, x, y;
    int n;
    op = ins[8:6]; x = ins[5:3]; y = ins[2:0];
    n  = (op >= 3'd2 && op <= 3'd5) ? 3 : 1;
    run = 1;
    din = ins;
    @(negedge clk);
    chk("t0_out", 32'(obs()), 32'd0);
    chk("t0_irin", 32'(ir_in), 32'd1);
    @(posedge clk); #1;
    for (int c = 1; c <= n; c++) begin
      run = 1'($urandom_range(0, 1));
      din = (c == 1) ? imm : 9'($urandom);
      @(negedge clk);
      chk($sformatf("op%0d_c%0d", op, c), 32'(obs()), 32'(exp_out(op, x, y, c)));
      chk("ir_stable", 32'(ir), 32'(ins));
      chk("busy_irin", 32'(ir_in), 32'd0);
      @(posedge clk); #1;
    end
    run = 0;
    case (op)
      3'd0: mr[x] = mr[y];
      3'd1: mr[x] = imm;
      3'd2: mr[x] = mr[x] + mr[y];
      3'd3: mr[x] = mr[x] - mr[y];
      3'd4: mr[x] = mr[x] & mr[y];
      3'd5: mr[x] = mr[x] | mr[y];
      default: ;
    endcase
    chk($sformatf("R%0d", x), 32'(R[x]), 32'(mr[x]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_out", 32'(obs()), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 8; i++) run_instr({3'b001, 3'(i), 3'b000}, 9'($urandom));

    run_instr(9'b001_010_000, 9'h0A5);
    chk("mvi_r2", 32'(R[2]), 32'h0A5);
    run_instr(9'b000_101_010, 9'h000);
    chk("mv_r5", 32'(R[5]), 32'h0A5);
    run_instr(9'b000_011_011, 9'h000);

    run_instr(9'b001_001_000, 9'd3);
    run_instr(9'b001_010_000, 9'd5);
    run_instr(9'b010_001_010, 9'h000);
    chk("add_r1", 32'(R[1]), 32'd8);
    run_instr(9'b001_001_000, 9'd3);
    run_instr(9'b011_001_010, 9'h000);
    chk("sub_r1", 32'(R[1]), 32'h1FE);
    run_instr(9'b100_000_111, 9'h000);
    run_instr(9'b101_110_100, 9'h000);
    run_instr(9'b110_011_001, 9'h000);
    run_instr(9'b111_000_000, 9'h000);
    idle(9'b111_000_000);

    // Abort an add in T2: state and IR clear, nothing written back.
    run = 1; din = 9'b010_001_010;
    @(posedge clk); #1;
    run = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_abort_t2", 32'(obs()), 32'(exp_out(3'd2, 3'd1, 3'd2, 2)));
    rst = 1;
    #1;
    chk("abort_out", 32'(obs()), 32'd0);
    chk("abort_ir", 32'(ir), 32'd0);
    @(posedge clk); #1;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_t0", 32'(obs()), 32'd0);
    rst = 0;
    chk("abort_r1", 32'(R[1]), 32'(mr[1]));
    idle(9'd0);

    for (int k = 0; k < 80; k++) begin
      run_instr(9'($urandom), 9'($urandom));
      if ($urandom_range(0, 3) == 0) idle(ir);
    end

    for (int i = 0; i < 8; i++) chk($sformatf("final_R%0d", i), 32'(R[i]), 32'(mr[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
